// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block.
// Optional build macro: PWM_CAPTURE_DEGLITCH_EN (3-cycle glitch filter on the
// synchronised PWM level).
package pwm_capture_pkg;

  // Measurement FSM; encodings match the legacy 2-bit state register.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEAS  = 2'd1,
    STUCK = 2'd2
  } state_t;

  // Default generator counter width; measurement width is N+1.
  localparam int unsigned DEFAULT_N           = 8;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

  // Consecutive disagreeing samples needed before the filtered level follows.
  localparam int unsigned DEGLITCH_RUN = 3;

  // Measurement width for a given generator counter width.
  function automatic int unsigned meas_width(input int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Front end of the PWM capture block: synchroniser for the asynchronous PWM
// line, optional glitch filter (PWM_CAPTURE_DEGLITCH_EN), and rising-edge
// detector. Outputs the usable line level and a one-cycle rise pulse.
module pwm_edge_sync
  import pwm_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  output logic level,
  output logic rise
);

  // Fewer than two stages would leave the line metastability-exposed.
  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              s;
  logic              prev_q;

  // Shift the raw line through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pwm_in};
    end
  end

  assign s = sync_q[STAGES-1];

`ifdef PWM_CAPTURE_DEGLITCH_EN
  logic       filt_q;
  logic [1:0] run_q;

  // Filtered level follows s only after DEGLITCH_RUN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q <= 1'b0;
      run_q  <= '0;
    end else if (s == filt_q) begin
      run_q <= '0;
    end else if (run_q == 2'(DEGLITCH_RUN - 1)) begin
      filt_q <= s;
      run_q  <= '0;
    end else begin
      run_q <= run_q + 2'd1;
    end
  end

  assign level = filt_q;
`else
  assign level = s;
`endif

  // Previous level, for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period (rising edge to rising edge) of
// an asynchronous PWM line in clk cycles, strobes valid on each completed
// period, and flags a line that has had no rising edge for MAX cycles.
// Optional build macro: PWM_CAPTURE_DEGLITCH_EN (handled in pwm_edge_sync).
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned N           = DEFAULT_N,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_in,
  output logic [N:0]   high_time,
  output logic [N:0]   period,
  output logic         valid,
  output logic         stuck,
  output logic         stuck_lvl
);

  localparam int unsigned W   = meas_width(N);
  localparam logic [W-1:0] MAX = '1;
  localparam logic [W-1:0] ONE = W'(1);

  logic         level;
  logic         rise;
  logic [W-1:0] per_q;
  logic [W-1:0] hi_q;
  logic         at_max;
  logic         go_stuck;
  state_t       state_q;

  pwm_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .pwm_in(pwm_in),
    .level (level),
    .rise  (rise)
  );

  // Saturating period and high-time counters, restarted at 1 on every rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      per_q <= '0;
      hi_q  <= '0;
    end else if (rise) begin
      per_q <= ONE;
      hi_q  <= ONE;
    end else begin
      if (per_q != MAX) begin
        per_q <= per_q + ONE;
      end
      if (level && (hi_q != MAX)) begin
        hi_q <= hi_q + ONE;
      end
    end
  end

  assign at_max   = (per_q == MAX);
  // A rise on the saturation cycle wins: it is a normal measurement.
  assign go_stuck = ((state_q == IDLE) || (state_q == MEAS)) && !rise && at_max;

  // Measurement FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      valid     <= 1'b0;
      stuck     <= 1'b0;
      stuck_lvl <= 1'b0;
      high_time <= '0;
      period    <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // The partial first period is never reported.
          if (rise) begin
            state_q <= MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            high_time <= hi_q;
            period    <= per_q;
            valid     <= 1'b1;
          end
        end
        STUCK: begin
          if (rise) begin
            state_q <= MEAS;
            stuck   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (go_stuck) begin
        state_q   <= STUCK;
        valid     <= 1'b1;
        stuck     <= 1'b1;
        stuck_lvl <= level;
        period    <= MAX;
        high_time <= level ? MAX : '0;
      end
    end
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's counter/comparator PWM generator.
- Samples an asynchronous PWM line and measures high time and period, rising edge to rising edge, in clk cycles.
- Reports each completed period with a one-cycle valid strobe.
- Flags a line stuck at a constant level (duty 0 / 100 %).
- Sits between a pad/loopback input and any register or comparison logic needing the recovered duty.

Parameters:
- N, 8, generator counter width; measurement width W = N+1, so a full 2^N-cycle period fits.
- SYNC_STAGES, 2, synchronizer flops on pwm_in (minimum 2).

Ports:
- clk  input  1  single clock, all logic on posedge.
- reset  input  1  synchronous, active-high.
- pwm_in  input  1  asynchronous PWM line.
- high_time  output  N+1  high cycles of last completed period.
- period  output  N+1  cycles between last two rising edges.
- valid  output  1  one-cycle pulse when high_time/period update.
- stuck  output  1  level; line had no rising edge for MAX = 2^(N+1)-1 cycles.
- stuck_lvl  output  1  line level when stuck asserted.

Behaviour:
- Reset (sync, active-high): all outputs 0; synchronizer and prev-sample flops 0; per_cnt = hi_cnt = 0; state IDLE.
- Front end:
  - pwm_in passes through SYNC_STAGES flops, then one prev flop. s = last sync stage.
  - rise = s & ~prev.
  - Latency from pwm_in edge to rise is SYNC_STAGES+1 cycles.
- Counters, width W, saturating at MAX:
  - On a rise cycle: per_cnt <= 1; hi_cnt <= 1.
  - Otherwise: per_cnt increments; hi_cnt increments only when s = 1. Neither wraps.
- States:
  - IDLE: after reset. per_cnt counts from reset. No valid is emitted; a partial first period is never reported.
    - rise -> MEAS.
    - per_cnt == MAX with no rise -> STUCK event.
  - MEAS:
    - rise -> register high_time = hi_cnt and period = per_cnt; valid = 1 the following cycle; stay in MEAS.
    - per_cnt == MAX with no rise -> STUCK event.
  - STUCK event (one cycle):
    - valid = 1, stuck = 1, stuck_lvl = s, period = MAX.
    - high_time = MAX if s = 1, else 0.
    - State -> STUCK.
  - STUCK:
    - No further valid; outputs held.
    - rise -> MEAS, stuck = 0, counters restart at 1. The next valid comes at the following rise.
- Boundary rules:
  - Rise coincident with per_cnt == MAX: rise wins; normal measurement with period = MAX.
  - Generator duty = 2^N-1: high 255, low 1 (N = 8); reported normally.
  - Generator duty = 0: line constant low -> STUCK, stuck_lvl = 0.
  - Glitch shorter than one clk is not guaranteed to be seen. Any sampled 1-cycle pulse is a legal edge unless the optional filter is compiled in.
  - Reset asserted mid-period: measurement discarded, no valid, back to IDLE.
- valid is never asserted on two consecutive cycles for period ≥ 2.
- high_time and period hold between valid pulses.

Optional Feature:
- Macro PWM_CAPTURE_DEGLITCH_EN.
- Defined:
  - A filtered level f replaces s. f changes only after s differs from f for 3 consecutive cycles.
  - Edge latency becomes SYNC_STAGES+4.
  - Pulses of 1–2 sampled cycles are ignored.
  - Reported high_time and period are unchanged for clean input.
- Undefined: f = s; no extra latency or logic.

Decomposition:
- Shared include file holds:
  - state encodings IDLE = 2'd0, MEAS = 2'd1, STUCK = 2'd2;
  - localparams W = N+1 and MAX = {W{1'b1}}.
- Natural sub-module: pwm_edge_sync, containing:
  - synchronizer + optional deglitch filter + prev flop;
  - outputs level f and pulse rise.
- Counters, state machine and output registers stay in pwm_capture.

Test Plan:
- N = 8, line driven by the team's PWM generator with duty = 64 -> after the second rise: valid every 256 cycles, period = 256, high_time = 64, stuck = 0.
- Generator duty = 200, then switched to 10 mid-period -> one transitional report, then period = 256, high_time = 10.
- pwm_in held 0 from reset:
  - valid + stuck at 511 cycles, stuck_lvl = 0, high_time = 0, period = 511, no further valid;
  - then generator duty = 128 -> stuck clears on rise; next report 256/128.
- pwm_in held 1 -> stuck = 1, stuck_lvl = 1, high_time = 511.
- Reset pulsed 100 cycles into a period -> no valid; outputs 0; first report only after two subsequent rises.
- With PWM_CAPTURE_DEGLITCH_EN, 2-cycle high glitch inside a low phase -> ignored, report unchanged. Without the macro -> glitch counted as a rise, short period reported.
